// File: rtl/dma_queue_pkg.sv
// Shared constants for the queued DMA controller: register map, STATUS/CLEAR/CTRL bit
// positions and the issue-FSM state encoding.
package dma_queue_pkg;

    localparam int ADDR_CTRL      = 0;
    localparam int ADDR_MM2S_ADDR = 1;
    localparam int ADDR_S2MM_ADDR = 2;
    localparam int ADDR_LEN       = 3;
    localparam int ADDR_USER      = 4;
    localparam int ADDR_PUSH      = 5;
    localparam int ADDR_STATUS    = 6;
    localparam int ADDR_DONE_CNT  = 7;
    localparam int ADDR_LAST_ERR  = 8;
    localparam int ADDR_CLEAR     = 9;

    localparam int CTRL_IRQ_EN = 0;
    localparam int CTRL_RUN    = 1;

    localparam int STAT_EMPTY    = 0;
    localparam int STAT_FULL     = 1;
    localparam int STAT_BUSY     = 2;
    localparam int STAT_ERR_OVF  = 3;
    localparam int STAT_ERR_MM2S = 4;
    localparam int STAT_ERR_S2MM = 5;
    localparam int STAT_ERR_TAG  = 6;
    localparam int STAT_IRQ      = 7;
    localparam int STAT_CNT_LSB  = 8;
    localparam int STAT_OST_LSB  = 16;

    localparam int CLR_ERR  = 0;
    localparam int CLR_DONE = 1;
    localparam int CLR_IRQ  = 2;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } issue_state_e;

endpackage

// File: rtl/dma_queue_ctrl_if.sv
// Register bus plus MM2S/S2MM descriptor and status channels of the queued DMA controller.
// slave = the controller itself; master = register bridge and DMA engines.
interface dma_queue_ctrl_if #(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_LEN_WIDTH   = 32,
    parameter int AXIS_USER_WIDTH = 8,
    parameter int AXI_TAG_WIDTH   = 8,
    parameter int REG_DATA_WIDTH  = 32,
    parameter int REG_ADDR_WIDTH  = 32
) ();
    logic                                    reg_wr_en;
    logic [REG_ADDR_WIDTH-1:0]               reg_wr_addr;
    logic [REG_DATA_WIDTH-1:0]               reg_wr_data;
    logic                                    reg_rd_en;
    logic [REG_ADDR_WIDTH-1:0]               reg_rd_addr;
    logic [REG_DATA_WIDTH-1:0]               reg_rd_data;

    logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] mm2s_desc;
    logic [AXIS_USER_WIDTH-1:0]              mm2s_user;
    logic                                    mm2s_valid;
    logic                                    mm2s_ready;
    logic [3:0]                              mm2s_status_error;
    logic                                    mm2s_status_valid;

    logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] s2mm_desc;
    logic [AXI_TAG_WIDTH-1:0]                s2mm_tag;
    logic                                    s2mm_valid;
    logic                                    s2mm_ready;
    logic [AXI_TAG_WIDTH-1:0]                s2mm_status_tag;
    logic [3:0]                              s2mm_status_error;
    logic                                    s2mm_status_valid;

    logic                                    irq;

    modport slave (
        input  reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
        output reg_rd_data,
        output mm2s_desc, mm2s_user, mm2s_valid,
        input  mm2s_ready, mm2s_status_error, mm2s_status_valid,
        output s2mm_desc, s2mm_tag, s2mm_valid,
        input  s2mm_ready, s2mm_status_tag, s2mm_status_error, s2mm_status_valid,
        output irq
    );

    modport master (
        output reg_wr_en, reg_wr_addr, reg_wr_data, reg_rd_en, reg_rd_addr,
        input  reg_rd_data,
        input  mm2s_desc, mm2s_user, mm2s_valid,
        output mm2s_ready, mm2s_status_error, mm2s_status_valid,
        input  s2mm_desc, s2mm_tag, s2mm_valid,
        output s2mm_ready, s2mm_status_tag, s2mm_status_error, s2mm_status_valid,
        input  irq
    );
endinterface

// File: rtl/dma_queue_ctrl_desc_fifo.sv
// Synchronous show-ahead FIFO with count/full/empty; latency 1 cycle write-to-visible.
// A write while full is accepted only when a read happens in the same cycle.
module desc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      i_wr_en,
    input  logic [WIDTH-1:0]          i_wr_dat,
    input  logic                      i_rd_en,
    output logic [WIDTH-1:0]          o_rd_dat,
    output logic [$clog2(DEPTH):0]    o_count,
    output logic                      o_full,
    output logic                      o_empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_do_wr;
    logic             w_do_rd;

    assign o_count  = r_count;
    assign o_full   = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign w_do_rd  = i_rd_en && !o_empty;
    assign w_do_wr  = i_wr_en && (!o_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr] <= i_wr_dat;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/dma_queue_ctrl.sv
// Queued DMA controller: register-staged descriptors issued to MM2S+S2MM with tag tracking.
// Latency PUSH->valid 2 cycles; issue stalls on run=0, empty queue or outstanding limit.
module dma_queue_ctrl
    import dma_queue_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int AXI_LEN_WIDTH   = 32,
    parameter int AXIS_USER_WIDTH = 8,
    parameter int AXI_TAG_WIDTH   = 8,
    parameter int REG_DATA_WIDTH  = 32,
    parameter int REG_ADDR_WIDTH  = 32,
    parameter int QUEUE_DEPTH     = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic            clk,
    input  logic            rstn,
    dma_queue_ctrl_if.slave bus
);
    localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int OST_W  = $clog2(MAX_OUTSTANDING + 1);
    localparam int DESC_W = 2*AXI_ADDR_WIDTH + AXI_LEN_WIDTH + AXIS_USER_WIDTH;

    localparam logic [REG_ADDR_WIDTH-1:0] A_CTRL = REG_ADDR_WIDTH'(ADDR_CTRL);
    localparam logic [REG_ADDR_WIDTH-1:0] A_MM2S = REG_ADDR_WIDTH'(ADDR_MM2S_ADDR);
    localparam logic [REG_ADDR_WIDTH-1:0] A_S2MM = REG_ADDR_WIDTH'(ADDR_S2MM_ADDR);
    localparam logic [REG_ADDR_WIDTH-1:0] A_LEN  = REG_ADDR_WIDTH'(ADDR_LEN);
    localparam logic [REG_ADDR_WIDTH-1:0] A_USER = REG_ADDR_WIDTH'(ADDR_USER);
    localparam logic [REG_ADDR_WIDTH-1:0] A_PUSH = REG_ADDR_WIDTH'(ADDR_PUSH);
    localparam logic [REG_ADDR_WIDTH-1:0] A_STAT = REG_ADDR_WIDTH'(ADDR_STATUS);
    localparam logic [REG_ADDR_WIDTH-1:0] A_DONE = REG_ADDR_WIDTH'(ADDR_DONE_CNT);
    localparam logic [REG_ADDR_WIDTH-1:0] A_LERR = REG_ADDR_WIDTH'(ADDR_LAST_ERR);
    localparam logic [REG_ADDR_WIDTH-1:0] A_CLR  = REG_ADDR_WIDTH'(ADDR_CLEAR);

    typedef struct packed {
        logic [AXI_ADDR_WIDTH-1:0]  mm2s_addr;
        logic [AXI_ADDR_WIDTH-1:0]  s2mm_addr;
        logic [AXI_LEN_WIDTH-1:0]   len;
        logic [AXIS_USER_WIDTH-1:0] user;
    } desc_t;

    logic [1:0]                              r_ctrl;
    logic [AXI_ADDR_WIDTH-1:0]               r_mm2s_addr;
    logic [AXI_ADDR_WIDTH-1:0]               r_s2mm_addr;
    logic [AXI_LEN_WIDTH-1:0]                r_len;
    logic [AXIS_USER_WIDTH-1:0]              r_user;
    logic                                    r_err_ovf, r_err_mm2s, r_err_s2mm, r_err_tag, r_irq;
    logic [31:0]                             r_done_cnt;
    logic [7:0]                              r_last_err;
    logic [AXI_TAG_WIDTH-1:0]                r_tag;
    logic [AXI_TAG_WIDTH-1:0]                r_exp_tag;
    logic [OST_W-1:0]                        r_outstanding;
    issue_state_e                            r_state;
    logic                                    r_mm2s_vld, r_s2mm_vld;
    logic [AXI_ADDR_WIDTH+AXI_LEN_WIDTH-1:0] r_mm2s_desc, r_s2mm_desc;
    logic [AXIS_USER_WIDTH-1:0]              r_mm2s_user;

    issue_state_e                            w_state_nxt;
    logic                                    w_issue_start, w_pop;
    desc_t                                   w_stage, w_head;
    logic [QCNT_W-1:0]                       w_qcount;
    logic                                    w_full, w_empty;
    logic                                    w_wr_push, w_wr_clear;
    logic                                    w_clr_err, w_clr_done, w_clr_irq;
    logic                                    w_mm2s_hs, w_s2mm_hs, w_mm2s_done, w_s2mm_done;
    logic                                    w_st_dec, w_drain;
    logic                                    w_ovf, w_mm2s_err, w_s2mm_err, w_tag_err, w_err_evt;
    logic [REG_DATA_WIDTH-1:0]               w_status, w_rd_data;

    assign w_wr_push  = bus.reg_wr_en && (bus.reg_wr_addr == A_PUSH);
    assign w_wr_clear = bus.reg_wr_en && (bus.reg_wr_addr == A_CLR);
    assign w_clr_err  = w_wr_clear && bus.reg_wr_data[CLR_ERR];
    assign w_clr_done = w_wr_clear && bus.reg_wr_data[CLR_DONE];
    assign w_clr_irq  = w_wr_clear && bus.reg_wr_data[CLR_IRQ];

    assign w_stage = {r_mm2s_addr, r_s2mm_addr, r_len, r_user};

    desc_fifo #(
        .WIDTH (DESC_W),
        .DEPTH (QUEUE_DEPTH)
    ) u_desc_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .i_wr_en  (w_wr_push),
        .i_wr_dat (w_stage),
        .i_rd_en  (w_pop),
        .o_rd_dat (w_head),
        .o_count  (w_qcount),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // A channel counts as done once its valid has already dropped or it handshakes now.
    assign w_mm2s_hs   = r_mm2s_vld && bus.mm2s_ready;
    assign w_s2mm_hs   = r_s2mm_vld && bus.s2mm_ready;
    assign w_mm2s_done = !r_mm2s_vld || w_mm2s_hs;
    assign w_s2mm_done = !r_s2mm_vld || w_s2mm_hs;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_issue_start = 1'b0;
        w_pop         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_ctrl[CTRL_RUN] && !w_empty && (r_outstanding < OST_W'(MAX_OUTSTANDING))) begin
                    w_state_nxt   = S_ISSUE;
                    w_issue_start = 1'b1;
                end
            end
            S_ISSUE: begin
                if (w_mm2s_done && w_s2mm_done) begin
                    w_state_nxt = S_IDLE;
                    w_pop       = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mm2s_vld  <= 1'b0;
            r_s2mm_vld  <= 1'b0;
            r_mm2s_desc <= '0;
            r_s2mm_desc <= '0;
            r_mm2s_user <= '0;
            r_tag       <= '0;
        end else begin
            if (w_issue_start) begin
                r_mm2s_vld  <= 1'b1;
                r_s2mm_vld  <= 1'b1;
                r_mm2s_desc <= {w_head.len, w_head.mm2s_addr};
                r_s2mm_desc <= {w_head.len, w_head.s2mm_addr};
                r_mm2s_user <= w_head.user;
            end else begin
                if (w_mm2s_hs) r_mm2s_vld <= 1'b0;
                if (w_s2mm_hs) r_s2mm_vld <= 1'b0;
            end
            if (w_s2mm_hs) r_tag <= r_tag + AXI_TAG_WIDTH'(1);
        end
    end

    assign w_st_dec   = bus.s2mm_status_valid && (r_outstanding != '0);
    assign w_drain    = w_st_dec && !w_s2mm_hs && (r_outstanding == OST_W'(1)) && w_empty;
    assign w_ovf      = w_wr_push && w_full && !w_pop;
    assign w_mm2s_err = bus.mm2s_status_valid && (bus.mm2s_status_error != 4'd0);
    assign w_s2mm_err = bus.s2mm_status_valid && (bus.s2mm_status_error != 4'd0);
    assign w_tag_err  = bus.s2mm_status_valid && (bus.s2mm_status_tag != r_exp_tag);
    assign w_err_evt  = w_ovf || w_mm2s_err || w_s2mm_err || w_tag_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ctrl        <= '0;
            r_mm2s_addr   <= '0;
            r_s2mm_addr   <= '0;
            r_len         <= '0;
            r_user        <= '0;
            r_outstanding <= '0;
            r_exp_tag     <= '0;
            r_done_cnt    <= '0;
        end else begin
            if (bus.reg_wr_en) begin
                case (bus.reg_wr_addr)
                    A_CTRL:  r_ctrl      <= bus.reg_wr_data[1:0];
                    A_MM2S:  r_mm2s_addr <= bus.reg_wr_data[AXI_ADDR_WIDTH-1:0];
                    A_S2MM:  r_s2mm_addr <= bus.reg_wr_data[AXI_ADDR_WIDTH-1:0];
                    A_LEN:   r_len       <= bus.reg_wr_data[AXI_LEN_WIDTH-1:0];
                    A_USER:  r_user      <= bus.reg_wr_data[AXIS_USER_WIDTH-1:0];
                    default: ;
                endcase
            end
            case ({w_s2mm_hs, w_st_dec})
                2'b10:   r_outstanding <= r_outstanding + OST_W'(1);
                2'b01:   r_outstanding <= r_outstanding - OST_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (bus.s2mm_status_valid) r_exp_tag <= r_exp_tag + AXI_TAG_WIDTH'(1);
            r_done_cnt <= (w_clr_done ? 32'd0 : r_done_cnt) + {31'd0, bus.s2mm_status_valid};
        end
    end

    // Clears are applied first so a same-cycle set wins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_ovf  <= 1'b0;
            r_err_mm2s <= 1'b0;
            r_err_s2mm <= 1'b0;
            r_err_tag  <= 1'b0;
            r_last_err <= '0;
            r_irq      <= 1'b0;
        end else begin
            if (w_clr_err) begin
                r_err_ovf  <= 1'b0;
                r_err_mm2s <= 1'b0;
                r_err_s2mm <= 1'b0;
                r_err_tag  <= 1'b0;
                r_last_err <= '0;
            end
            if (w_ovf)     r_err_ovf <= 1'b1;
            if (w_tag_err) r_err_tag <= 1'b1;
            if (w_mm2s_err) begin
                r_err_mm2s      <= 1'b1;
                r_last_err[3:0] <= bus.mm2s_status_error;
            end
            if (w_s2mm_err) begin
                r_err_s2mm      <= 1'b1;
                r_last_err[7:4] <= bus.s2mm_status_error;
            end
            if (w_clr_irq) r_irq <= 1'b0;
            if (r_ctrl[CTRL_IRQ_EN] && (w_drain || w_err_evt)) r_irq <= 1'b1;
        end
    end

    always_comb begin
        w_status                     = '0;
        w_status[STAT_EMPTY]         = w_empty;
        w_status[STAT_FULL]          = w_full;
        w_status[STAT_BUSY]          = !w_empty || (r_outstanding != '0);
        w_status[STAT_ERR_OVF]       = r_err_ovf;
        w_status[STAT_ERR_MM2S]      = r_err_mm2s;
        w_status[STAT_ERR_S2MM]      = r_err_s2mm;
        w_status[STAT_ERR_TAG]       = r_err_tag;
        w_status[STAT_IRQ]           = r_irq;
        w_status[STAT_CNT_LSB +: 8]  = 8'(w_qcount);
        w_status[STAT_OST_LSB +: 8]  = 8'(r_outstanding);
    end

    always_comb begin
        w_rd_data = '0;
        if (bus.reg_rd_en) begin
            case (bus.reg_rd_addr)
                A_CTRL:  w_rd_data = REG_DATA_WIDTH'(r_ctrl);
                A_MM2S:  w_rd_data = REG_DATA_WIDTH'(r_mm2s_addr);
                A_S2MM:  w_rd_data = REG_DATA_WIDTH'(r_s2mm_addr);
                A_LEN:   w_rd_data = REG_DATA_WIDTH'(r_len);
                A_USER:  w_rd_data = REG_DATA_WIDTH'(r_user);
                A_STAT:  w_rd_data = w_status;
                A_DONE:  w_rd_data = REG_DATA_WIDTH'(r_done_cnt);
                A_LERR:  w_rd_data = REG_DATA_WIDTH'(r_last_err);
                default: w_rd_data = '0;
            endcase
        end
    end

    assign bus.reg_rd_data = w_rd_data;
    assign bus.mm2s_desc   = r_mm2s_desc;
    assign bus.mm2s_user   = r_mm2s_user;
    assign bus.mm2s_valid  = r_mm2s_vld;
    assign bus.s2mm_desc   = r_s2mm_desc;
    assign bus.s2mm_tag    = r_tag;
    assign bus.s2mm_valid  = r_s2mm_vld;
    assign bus.irq         = r_irq;
endmodule
